adc_sample_conditioner: RTL and testbench

Sits directly downstream of the SPI ADC receiver and upstream of the FIR and IIR filter stages. It accepts 12-bit offset-binary ADC words qualified by a level-type valid, captures each word once on the valid's rising edge, and converts it to two's complement when enabled. Samples are buffered in a small FIFO and presented to the filters over a valid/ready handshake. It also reports ADC clipping and FIFO overflow.

---
 rtl/dsp_pkg.sv | 8 +
 rtl/sample_fifo.sv | 51 +++++
 rtl/adc_sample_conditioner.sv | 70 +++++++
 tb/tb_adc_sample_conditioner.sv | 172 +++++++++++++++++
 4 files changed

// File: rtl/dsp_pkg.sv
// Shared constants for the ADC front-end datapath.
package dsp_pkg;
    localparam int DEF_DATA_W = 12;

    localparam logic [11:0] ADC_MID = 12'h800;
    localparam logic [11:0] ADC_MIN = 12'h000;
    localparam logic [11:0] ADC_MAX = 12'hFFF;
endpackage

// File: rtl/sample_fifo.sv
// First-word-fall-through sample FIFO. Pointers carry one extra wrap bit,
// so occupancy is the pointer difference.
module sample_fifo #(
    parameter int WIDTH = 12,
    parameter int DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     wr_en,
    input  logic [WIDTH-1:0]         din,
    input  logic                     rd_en,
    output logic [WIDTH-1:0]         dout,
    output logic                     empty,
    output logic                     full,
    output logic [$clog2(DEPTH):0]   level
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW:0]      r_wr_ptr;
    logic [AW:0]      r_rd_ptr;
    logic             w_wr;
    logic             w_rd;

    assign level = r_wr_ptr - r_rd_ptr;
    assign empty = (level == '0);
    assign full  = (level == (AW+1)'(DEPTH));
    assign dout  = r_mem[r_rd_ptr[AW-1:0]];

    // A write into a full FIFO is only legal when the head leaves on the same edge.
    assign w_rd = rd_en & ~empty;
    assign w_wr = wr_en & (~full | w_rd);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else begin
            if (w_wr) begin
                r_mem[r_wr_ptr[AW-1:0]] <= din;
                r_wr_ptr                <= r_wr_ptr + 1'b1;
            end
            if (w_rd) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
        end
    end
endmodule

// File: rtl/adc_sample_conditioner.sv
// Captures one ADC word per rising edge of din_valid, converts offset-binary
// to two's complement, buffers it and flags clipping and dropped samples.
module adc_sample_conditioner #(
    parameter int DATA_W     = dsp_pkg::DEF_DATA_W,
    parameter int DEPTH      = 8,
    parameter bit SIGNED_OUT = 1'b1
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [DATA_W-1:0]        din,
    input  logic                     din_valid,
    output logic [DATA_W-1:0]        dout,
    output logic                     dout_valid,
    input  logic                     dout_ready,
    output logic [$clog2(DEPTH):0]   level,
    output logic                     clip,
    output logic                     overflow,
    input  logic                     clear_ovf
);
    logic              r_din_valid_q;
    logic              r_clip;
    logic              r_overflow;
    logic              w_wr_evt;
    logic              w_rd_evt;
    logic              w_empty;
    logic              w_full;
    logic              w_raw_clip;
    logic [DATA_W-1:0] w_word;

    assign w_wr_evt   = din_valid & ~r_din_valid_q;
    assign w_rd_evt   = dout_valid & dout_ready;
    assign w_raw_clip = (din == '0) | (din == '1);
    assign w_word     = SIGNED_OUT ? {~din[DATA_W-1], din[DATA_W-2:0]} : din;

    assign dout_valid = ~w_empty;
    assign clip       = r_clip;
    assign overflow   = r_overflow;

    sample_fifo #(
        .WIDTH (DATA_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .wr_en (w_wr_evt),
        .din   (w_word),
        .rd_en (w_rd_evt),
        .dout  (dout),
        .empty (w_empty),
        .full  (w_full),
        .level (level)
    );

    // History resets high so a valid already asserted at reset release is ignored.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_din_valid_q <= 1'b1;
            r_clip        <= 1'b0;
            r_overflow    <= 1'b0;
        end else begin
            r_din_valid_q <= din_valid;
            r_clip        <= w_wr_evt & w_raw_clip;
            if (w_wr_evt & w_full & ~w_rd_evt) begin
                r_overflow <= 1'b1;
            end else if (clear_ovf) begin
                r_overflow <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_adc_sample_conditioner.sv
// Directed bench for adc_sample_conditioner with hand-computed expectations.
module tb_adc_sample_conditioner;
    import dsp_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic [11:0] din;
    logic        din_valid;
    logic [11:0] dout;
    logic        dout_valid;
    logic        dout_ready;
    logic [3:0]  level;
    logic        clip;
    logic        overflow;
    logic        clear_ovf;

    int n_chk  = 0;
    int n_fail = 0;

    adc_sample_conditioner #(
        .DATA_W     (12),
        .DEPTH      (8),
        .SIGNED_OUT (1'b1)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .din        (din),
        .din_valid  (din_valid),
        .dout       (dout),
        .dout_valid (dout_valid),
        .dout_ready (dout_ready),
        .level      (level),
        .clip       (clip),
        .overflow   (overflow),
        .clear_ovf  (clear_ovf)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse(input logic [11:0] d);
        din       = d;
        din_valid = 1'b1;
        step();
        din_valid = 1'b0;
        step();
    endtask

    initial begin
        rst        = 1'b1;
        din        = 12'h123;
        din_valid  = 1'b1;
        dout_ready = 1'b0;
        clear_ovf  = 1'b0;
        step();
        step();
        chk("rst_level", 32'(level), 0);
        chk("rst_dout", 32'(dout), 0);
        chk("rst_clip", 32'(clip), 0);
        chk("rst_ovf", 32'(overflow), 0);
        // Release with valid held high: no capture expected.
        rst = 1'b0;
        repeat (3) step();
        chk("hold_level", 32'(level), 0);
        chk("hold_valid", 32'(dout_valid), 0);
        din_valid = 1'b0;
        step();

        // Long valid pulse on mid-scale: one write of zero.
        din       = ADC_MID;
        din_valid = 1'b1;
        step();
        chk("mid_valid", 32'(dout_valid), 1);
        chk("mid_dout", 32'(dout), 32'h000);
        chk("mid_clip", 32'(clip), 0);
        repeat (4) step();
        chk("mid_level_held", 32'(level), 1);
        din_valid  = 1'b0;
        dout_ready = 1'b1;
        step();
        chk("mid_drained", 32'(level), 0);

        // Extremes and a mid value streaming straight through.
        din = ADC_MIN; din_valid = 1'b1; step();
        chk("min_dout", 32'(dout), 32'h800);
        chk("min_clip", 32'(clip), 1);
        din_valid = 1'b0; step();
        chk("min_clip_end", 32'(clip), 0);
        chk("min_read", 32'(level), 0);
        din = ADC_MAX; din_valid = 1'b1; step();
        chk("max_dout", 32'(dout), 32'h7FF);
        chk("max_clip", 32'(clip), 1);
        din_valid = 1'b0; step();
        din = 12'hA00; din_valid = 1'b1; step();
        chk("a00_dout", 32'(dout), 32'h200);
        chk("a00_clip", 32'(clip), 0);
        din_valid = 1'b0; step();
        chk("stream_empty", 32'(dout_valid), 0);

        // Fill past capacity with no reader.
        dout_ready = 1'b0;
        for (int i = 0; i < 8; i++) pulse(12'h101 + 12'(i));
        chk("fill_level", 32'(level), 8);
        chk("fill_no_ovf", 32'(overflow), 0);
        pulse(12'h1FF);
        chk("drop_level", 32'(level), 8);
        chk("drop_ovf", 32'(overflow), 1);
        dout_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            chk($sformatf("drain%0d", i), 32'(dout), 32'h901 + 32'(i));
            step();
        end
        dout_ready = 1'b0;
        chk("drain_empty", 32'(dout_valid), 0);
        chk("drain_ovf_sticky", 32'(overflow), 1);
        clear_ovf = 1'b1; step(); clear_ovf = 1'b0;
        chk("ovf_cleared", 32'(overflow), 0);

        // Full FIFO: write plus read on one edge, then set beats clear.
        for (int i = 0; i < 8; i++) pulse(12'h301 + 12'(i));
        din = 12'h3AA; din_valid = 1'b1; dout_ready = 1'b1; step();
        chk("wr_rd_full_level", 32'(level), 8);
        chk("wr_rd_full_ovf", 32'(overflow), 0);
        din_valid = 1'b0; dout_ready = 1'b0; step();
        pulse(12'h3BB);
        chk("drop2_ovf", 32'(overflow), 1);
        din = 12'h3CC; din_valid = 1'b1; clear_ovf = 1'b1; step();
        chk("set_beats_clear", 32'(overflow), 1);
        din_valid = 1'b0; clear_ovf = 1'b0; step();
        dout_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            chk($sformatf("order%0d", i),
                32'(dout), (i == 7) ? 32'hBAA : 32'hB02 + 32'(i));
            step();
        end
        dout_ready = 1'b0;
        chk("order_empty", 32'(level), 0);

        // Reset in the middle of a burst, overflow still set from above.
        for (int i = 0; i < 4; i++) pulse(12'h401 + 12'(i));
        din = ADC_MAX; din_valid = 1'b1; step();
        chk("pre_rst_level", 32'(level), 5);
        chk("pre_rst_clip", 32'(clip), 1);
        chk("pre_rst_ovf", 32'(overflow), 1);
        rst = 1'b1;
        #1;
        chk("mid_rst_level", 32'(level), 0);
        chk("mid_rst_valid", 32'(dout_valid), 0);
        chk("mid_rst_dout", 32'(dout), 0);
        chk("mid_rst_ovf", 32'(overflow), 0);
        chk("mid_rst_clip", 32'(clip), 0);
        step();
        rst = 1'b0;
        step();
        chk("post_rst_no_capture", 32'(level), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
